// File: rtl/alu_result_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_tx_pkg
//  Description : Shared definitions for the UART transmit path: FSM state
//                encoding, oversampling factor and default baud divider.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_result_tx_pkg;

    // Oversample ticks per bit period and the width of the tick counter.
    localparam int OVERSAMPLE       = 16;
    localparam int TICK_W           = 4;

    // 50 MHz / (19200 * 16)
    localparam int DEFAULT_BAUD_DIV = 163;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // True when the tick counter holds the final tick of an n-tick interval.
    function automatic logic last_tick(input logic [TICK_W-1:0] cnt, input int n);
        return cnt == TICK_W'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_tx_baud_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_rate_gen
//  Description : Free-running divider producing one-cycle oversample ticks.
//                Counts 0..BAUD_DIV-1; o_tick is high while the count sits at
//                BAUD_DIV-1. i_clear restarts the count so a frame begins on
//                a known phase.
//  Revision    : 1.0  initial release
// ============================================================================
module baud_rate_gen
    import alu_result_tx_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int NB_DIV   = 8
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    logic [NB_DIV-1:0] cnt_q;
    logic              at_top;

    assign at_top = (cnt_q == NB_DIV'(BAUD_DIV - 1));
    assign o_tick = at_top;

    // Divider counter: wraps at BAUD_DIV-1, restarted by reset or clear.
    always_ff @(posedge clock) begin
        if (i_reset || i_clear) begin
            cnt_q <= '0;
        end else if (at_top) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + NB_DIV'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_tx
//  Description : UART 8N1 transmitter for the ALU result byte. Latches the
//                byte on an accepted start request and shifts it out LSB
//                first with start and stop bits, 16 oversample ticks per bit.
//                All outputs are registered, so the line follows the FSM state
//                by one clock.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_tx
    import alu_result_tx_pkg::*;
#(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
    parameter int NB_DIV   = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done
);

    localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    tx_state_e          state_q;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [IDX_W-1:0]   bit_idx_q;
    logic [NB_DATA-1:0] shreg_q;
    logic               tx_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               tick;

    // A request is only honoured from IDLE; the same edge restarts the divider.
    assign accept = (state_q == ST_IDLE) && i_tx_start;

    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV),
        .NB_DIV   (NB_DIV)
    ) u_baud_rate_gen (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_clear  (accept),
        .o_tick   (tick)
    );

    // Frame sequencer: state, tick/bit counters, shift register and outputs.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (i_tx_start) begin
                        shreg_q    <= i_data;
                        tick_cnt_q <= '0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    tx_q   <= 1'b0;
                    busy_q <= 1'b1;
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        if (last_tick(tick_cnt_q, OVERSAMPLE)) begin
                            bit_idx_q <= '0;
                            state_q   <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    tx_q   <= shreg_q[0];
                    busy_q <= 1'b1;
                    if (tick) begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        if (last_tick(tick_cnt_q, OVERSAMPLE)) begin
                            shreg_q <= shreg_q >> 1;
                            if (bit_idx_q == IDX_W'(NB_DATA - 1)) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + IDX_W'(1);
                            end
                        end
                    end
                end

                ST_STOP: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b1;
                    if (tick) begin
                        if (last_tick(tick_cnt_q, SB_TICK)) begin
                            tick_cnt_q <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_tx_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_tx
//  Description : Self-checking bench for alu_result_tx with BAUD_DIV=4.
//                Expected line/busy/done values come from a frame-timeline
//                model: cycles since acceptance map onto the 10 frame bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_tx;

    localparam int NB_DATA   = 8;
    localparam int SB_TICK   = 16;
    localparam int BAUD_DIV  = 4;
    localparam int NB_DIV    = 8;
    localparam int BIT_CYC   = 16 * BAUD_DIV;
    localparam int FRAME_CYC = (16 * (NB_DATA + 1) + SB_TICK) * BAUD_DIV;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    wire                o_tx;
    wire                o_busy;
    wire                o_tx_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: is a frame running, cycles since acceptance,
    // and the frame bit sequence (index 0 = start bit, 9 = stop bit).
    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [9:0]  m_frame  = '1;
    int          done_seen = 0;

    alu_result_tx #(
        .NB_DATA   (NB_DATA),
        .SB_TICK   (SB_TICK),
        .BAUD_DIV  (BAUD_DIV),
        .NB_DIV    (NB_DIV)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_tx_done  (o_tx_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs for one edge, advance the model, compare all outputs.
    task automatic step(input logic rst, input logic start, input logic [NB_DATA-1:0] data);
        logic e_tx, e_busy, e_done;
        i_reset    = rst;
        i_tx_start = start;
        i_data     = data;
        @(posedge clock);
        #1;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = {1'b1, data, 1'b0};
            end
        end else begin
            m_t++;
            if (m_t == FRAME_CYC) begin
                m_active = 1'b0;
                e_done   = 1'b1;
            end else begin
                e_tx   = m_frame[(m_t - 1) / BIT_CYC];
                e_busy = 1'b1;
            end
        end
        check_eq("tx", o_tx, e_tx);
        check_eq("busy", o_busy, e_busy);
        check_eq("done", o_tx_done, e_done);
        if (o_tx_done) done_seen++;
    endtask

    // Send one byte and decode it independently by mid-bit sampling;
    // optionally scramble i_data every cycle while the frame runs.
    task automatic send_decode(input string tag, input logic [NB_DATA-1:0] data, input bit scramble);
        logic [9:0] got;
        int         done_at;
        int         d0;
        got     = '0;
        done_at = -1;
        d0      = done_seen;
        step(1'b0, 1'b1, data);
        for (int c = 1; c <= FRAME_CYC + 4; c++) begin
            step(1'b0, 1'b0, scramble ? NB_DATA'($urandom) : data);
            if (c >= BIT_CYC / 2 && c < FRAME_CYC && ((c - BIT_CYC / 2) % BIT_CYC) == 0)
                got[(c - BIT_CYC / 2) / BIT_CYC] = o_tx;
            if (o_tx_done && done_at < 0) done_at = c;
        end
        check_eq({tag, "_bits"}, {22'd0, got}, {22'd0, 1'b1, data, 1'b0});
        check_eq({tag, "_done_at"}, done_at, FRAME_CYC);
        check_eq({tag, "_done_cnt"}, done_seen - d0, 1);
    endtask

    initial begin
        int d0;
        i_reset    = 1'b1;
        i_tx_start = 1'b0;
        i_data     = '0;

        // 1. reset and idle
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'hFF);
        repeat (100) step(1'b0, 1'b0, NB_DATA'($urandom));

        // 2. single frame, explicit bit pattern 0,1,0,1,0,0,1,0,1,1
        send_decode("t2", 8'hA5, 1'b0);

        // 3. start while busy is ignored
        d0 = done_seen;
        step(1'b0, 1'b1, 8'h3C);
        repeat (199) step(1'b0, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'hFF);
        repeat (FRAME_CYC) step(1'b0, 1'b0, 8'hFF);
        check_eq("t3_done_cnt", done_seen - d0, 1);

        // 4. back-to-back: start held through the done cycle
        d0 = done_seen;
        step(1'b0, 1'b1, 8'h00);
        repeat (FRAME_CYC + 1) step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t4_second_start", o_tx, 1'b0);
        repeat (FRAME_CYC + 4) step(1'b0, 1'b0, 8'h00);
        check_eq("t4_done_cnt", done_seen - d0, 2);

        // 5. reset mid-frame aborts; next frame is normal
        d0 = done_seen;
        step(1'b0, 1'b1, 8'h81);
        repeat (299) step(1'b0, 1'b0, 8'h81);
        step(1'b1, 1'b0, 8'h81);
        check_eq("t5_tx_after_rst", o_tx, 1'b1);
        check_eq("t5_busy_after_rst", o_busy, 1'b0);
        repeat (FRAME_CYC) step(1'b0, 1'b0, 8'h81);
        check_eq("t5_abort_done_cnt", done_seen - d0, 0);
        send_decode("t5_after", 8'hC3, 1'b0);

        // 6. i_data noise during a frame
        send_decode("t6", 8'h5A, 1'b1);

        // Random traffic: gaps, stray starts, data noise, back-to-back accepts
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 20)) step(1'b0, 1'b0, NB_DATA'($urandom));
            step(1'b0, 1'b1, NB_DATA'($urandom));
            repeat (FRAME_CYC + $urandom_range(0, 3))
                step(1'b0, ($urandom_range(0, 15) == 0), NB_DATA'($urandom));
        end
        repeat (FRAME_CYC + 4) step(1'b0, 1'b0, '0);
        send_decode("rand", NB_DATA'($urandom), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
